scpu_out_capture: RTL and testbench

Output-side capture stage placed directly downstream of the SCPU `ext_out` port. It samples the CPU's 8-bit output every clock and detects value changes. Each changed value is pushed into a small show-ahead FIFO, so that a slower consumer (display driver, UART bridge, bench monitor) sees every distinct output value in order through a valid/ready handshake. Overflow is flagged rather than stalling the CPU, because the CPU has no back-pressure input.

---
 rtl/scpu_out_capture.sv | 93 +++++++++
 tb/tb_scpu_out_capture.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/scpu_out_capture.sv
// Change-capture stage behind the SCPU ext_out port.
// Each distinct CPU output value is queued in a show-ahead FIFO for a slower consumer.
module scpu_out_capture #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         cpu_out,
    input  logic                     cap_en,
    input  logic                     clr_ovf,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [WIDTH-1:0]         last_value
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    logic change;
    logic push;
    logic pop;
    logic full;
    logic push_ok;
    logic drop;

    // Push is accepted when full only if a pop frees a slot in the same cycle.
    always_comb begin
        change  = (cpu_out != last_value);
        push    = cap_en & change;
        pop     = dout_valid & dout_ready;
        full    = (count == CW'(DEPTH));
        push_ok = push & (~full | pop);
        drop    = push & full & ~pop;
    end

    assign dout_valid = (count != '0);
    assign dout       = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_value <= '0;
        end else begin
            last_value <= cpu_out;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok) begin
            mem[wr_ptr] <= cpu_out;
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy is tracked separately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop);
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_scpu_out_capture.sv
// Scoreboard bench for scpu_out_capture: a reference queue tracks expected
// FIFO contents, overflow and last_value; drained data is compared in order.
module tb_scpu_out_capture;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] cpu_out;
    logic             cap_en;
    logic             clr_ovf;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic [CW-1:0]    count;
    logic             overflow;
    logic [WIDTH-1:0] last_value;

    scpu_out_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_out    (cpu_out),
        .cap_en     (cap_en),
        .clr_ovf    (clr_ovf),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .count      (count),
        .overflow   (overflow),
        .last_value (last_value)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] sb [$];
    logic [WIDTH-1:0] m_last;
    logic             m_ovf;
    int               n_checks = 0;
    int               n_errors = 0;
    int               n_deliv  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of stimulus: model the cycle, compare the popped head before the edge,
    // then compare the registered state after the edge.
    task automatic step(input logic [7:0] c, input logic en, input logic rdy, input logic clr);
        logic m_pop;
        logic m_push;
        logic m_drop;
        cpu_out    = c;
        cap_en     = en;
        dout_ready = rdy;
        clr_ovf    = clr;
        #1;
        check("valid_pre", 32'(dout_valid), 32'(sb.size() != 0));
        m_pop = (sb.size() != 0) && rdy;
        if (m_pop) begin
            check("dout", 32'(dout), 32'(sb[0]));
            void'(sb.pop_front());
            n_deliv++;
        end
        m_push = en && (c != m_last);
        m_drop = m_push && (sb.size() >= int'(DEPTH));
        if (m_push && !m_drop) sb.push_back(c);
        if (m_drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_last = c;
        @(posedge clk);
        #1;
        check("count", 32'(count), 32'(sb.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("last_value", 32'(last_value), 32'(m_last));
        check("valid", 32'(dout_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) check("head", 32'(dout), 32'(sb[0]));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dout"}, 32'(dout), 32'(0));
        check({tag, "_valid"}, 32'(dout_valid), 32'(0));
        check({tag, "_count"}, 32'(count), 32'(0));
        check({tag, "_ovf"}, 32'(overflow), 32'(0));
        check({tag, "_last"}, 32'(last_value), 32'(0));
    endtask

    initial begin
        logic [7:0] seq [5];
        rst        = 1'b0;
        cpu_out    = 8'h00;
        cap_en     = 1'b0;
        clr_ovf    = 1'b0;
        dout_ready = 1'b0;
        m_last     = '0;
        m_ovf      = 1'b0;
        #12;
        check_reset_outputs("rst0");
        #11 rst = 1'b1;

        // Constant value held: exactly one item delivered.
        for (int i = 0; i < 20; i++) step(8'h0F, 1'b1, 1'b1, 1'b0);
        check("single_deliv", 32'(n_deliv), 32'(1));

        // Ordered fill with a repeated value, then drain.
        seq = '{8'h01, 8'h02, 8'h01, 8'h01, 8'h03};
        for (int i = 0; i < 5; i++) step(seq[i], 1'b1, 1'b0, 1'b0);
        check("fill4", 32'(count), 32'(4));
        for (int i = 0; i < 5; i++) step(8'h03, 1'b1, 1'b1, 1'b0);

        // Overflow on the fifth value, sticky until cleared.
        for (int i = 0; i < 5; i++) step(8'h10 + 8'(i), 1'b1, 1'b0, 1'b0);
        check("ovf_set", 32'(overflow), 32'(1));
        step(8'h14, 1'b1, 1'b0, 1'b0);
        step(8'h14, 1'b1, 1'b0, 1'b1);
        check("ovf_clr", 32'(overflow), 32'(0));
        // Drop and clear together: set wins.
        step(8'h55, 1'b1, 1'b0, 1'b1);
        check("ovf_setwins", 32'(overflow), 32'(1));
        step(8'h55, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(8'h55, 1'b1, 1'b1, 1'b0);

        // Full with simultaneous pop and push, across pointer wrap.
        for (int i = 0; i < 4; i++) step(8'h21 + 8'(i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(8'h31 + 8'(i), 1'b1, 1'b1, 1'b0);
            check("full_pp_count", 32'(count), 32'(4));
        end
        for (int i = 0; i < 5; i++) step(8'h33, 1'b1, 1'b1, 1'b0);

        // Capture disabled while the value changes.
        step(8'h10, 1'b0, 1'b1, 1'b0);
        step(8'h20, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(8'h20, 1'b1, 1'b1, 1'b0);
        check("capen_last", 32'(last_value), 32'(8'h20));

        // Asynchronous reset mid-drain.
        for (int i = 0; i < 3; i++) step(8'h41 + 8'(i), 1'b1, 1'b0, 1'b0);
        check("pre_rst_count", 32'(count), 32'(3));
        step(8'h43, 1'b1, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        sb.delete();
        m_last  = '0;
        m_ovf   = 1'b0;
        cpu_out = 8'h00;
        #2 rst = 1'b1;
        for (int i = 0; i < 5; i++) step(8'h00, 1'b1, 1'b1, 1'b0);
        check("post_rst_count", 32'(count), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
